// File: rtl/rtermcal_pkg.sv
// Shared types and constants for the termination-resistor calibration controller.
package rtermcal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_NEXT_CH,
    S_DONE
  } state_t;

  localparam logic ALGO_SAR = 1'b0;
  localparam logic ALGO_LIN = 1'b1;

  function automatic int unsigned therm_w(input int unsigned code_w);
    return (1 << code_w) - 1;
  endfunction

endpackage

// File: rtl/rtermcal_bin2therm.sv
// Binary trim code to thermometer code: bit i is set when code > i.
module rtermcal_bin2therm
  import rtermcal_pkg::*;
#(
  parameter int unsigned CODE_W = 4
) (
  input  logic [CODE_W-1:0]          code_i,
  output logic [therm_w(CODE_W)-1:0] therm_o
);

  always_comb begin
    therm_o = '0;
    for (int unsigned i = 0; i < therm_w(CODE_W); i++) begin
      therm_o[i] = (code_i > CODE_W'(i));
    end
  end

endmodule

// File: rtl/rtermcal_ctrl.sv
// Termination calibration controller: per enabled channel, SAR or linear-tracking
// search of the trim code against a majority-voted, synchronised comparator.
module rtermcal_ctrl
  import rtermcal_pkg::*;
#(
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned VOTE_N     = 3,
  parameter int unsigned RST_CODE   = 2 ** (CODE_W - 1)
) (
  input  logic                               CLK_I,
  input  logic                               RSTN_I,
  input  logic                               START_I,
  input  logic [N_CH-1:0]                    CH_EN_I,
  input  logic                               ALGO_I,
  input  logic                               CMP_I,
  output logic [N_CH-1:0]                    MODE_O,
  output logic [N_CH*CODE_W-1:0]             CODE_O,
  output logic [N_CH*therm_w(CODE_W)-1:0]    THERM_O,
  output logic                               BUSY_O,
  output logic                               DONE_O,
  output logic [N_CH-1:0]                    ERR_O
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned SC_W  = $clog2(SETTLE_CYC);
  localparam int unsigned TW    = therm_w(CODE_W);

  localparam logic [CODE_W-1:0] RST_V     = CODE_W'(RST_CODE);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
  localparam logic [CODE_W-1:0] SAR_INIT  = CODE_ONE << (CODE_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(CODE_W - 1);
  localparam logic [SC_W-1:0]   SET_LAST  = SC_W'(SETTLE_CYC - 1);
  localparam logic [2:0]        VOTE_LAST = 3'(VOTE_N - 1);
  localparam logic [2:0]        VOTE_HALF = 3'(VOTE_N / 2);

  state_t              state_q;
  logic [CODE_W-1:0]   code_q [N_CH];
  logic [N_CH-1:0]     pend_q, mode_q, err_q;
  logic [CH_W-1:0]     ch_q;
  logic [BIT_W-1:0]    bit_q;
  logic [SC_W-1:0]     cnt_q;
  logic [2:0]          vcnt_q, ones_q;
  logic                algo_q, dec_q, prev_q, first_q;
  logic                busy_q, done_q;
  logic                cmp_meta_q, cmp_s_q;

  logic                nxt_found;
  logic [CH_W-1:0]     nxt_ch;
  logic [CODE_W-1:0]   cur_code, dec_code;
  logic                dec_fin;
  logic [2:0]          ones_d;

  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (pend_q[i-1]) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i - 1);
      end
    end
  end

  // Linear finishes on the first decision flip; d=1 after a flip means the
  // previous (lower) code was the last one with d=0.
  always_comb begin
    cur_code = code_q[ch_q];
    dec_code = cur_code;
    dec_fin  = 1'b0;
    if (algo_q == ALGO_SAR) begin
      if (dec_q) dec_code[bit_q] = 1'b0;
      if (bit_q == '0) dec_fin = 1'b1;
      else dec_code[bit_q - BIT_ONE] = 1'b1;
    end else if (!first_q && (dec_q != prev_q)) begin
      dec_fin  = 1'b1;
      dec_code = dec_q ? cur_code - CODE_ONE : cur_code;
    end else if ((!dec_q && cur_code == CODE_MAX) || (dec_q && cur_code == '0)) begin
      dec_fin = 1'b1;
    end else begin
      dec_code = dec_q ? cur_code - CODE_ONE : cur_code + CODE_ONE;
    end
  end

  assign ones_d = ones_q + {2'b00, cmp_s_q};

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= CMP_I;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < N_CH; i++) code_q[i] <= RST_V;
      pend_q  <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      ch_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      vcnt_q  <= '0;
      ones_q  <= '0;
      algo_q  <= ALGO_SAR;
      dec_q   <= 1'b0;
      prev_q  <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START_I) begin
            pend_q  <= CH_EN_I;
            algo_q  <= ALGO_I;
            busy_q  <= 1'b1;
            state_q <= S_NEXT_CH;
          end
        end
        S_NEXT_CH: begin
          if (nxt_found) begin
            ch_q    <= nxt_ch;
            mode_q  <= N_CH'(1) << nxt_ch;
            if (algo_q == ALGO_SAR) code_q[nxt_ch] <= SAR_INIT;
            bit_q   <= BIT_TOP;
            first_q <= 1'b1;
            state_q <= S_SEL;
          end else begin
            mode_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_SEL: begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            cnt_q   <= '0;
            vcnt_q  <= '0;
            ones_q  <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + SC_W'(1);
          end
        end
        S_SAMPLE: begin
          ones_q <= ones_d;
          vcnt_q <= vcnt_q + 3'd1;
          if (vcnt_q == VOTE_LAST) begin
            dec_q   <= (ones_d > VOTE_HALF);
            state_q <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          code_q[ch_q] <= dec_code;
          prev_q       <= dec_q;
          first_q      <= 1'b0;
          bit_q        <= bit_q - BIT_ONE;
          if (dec_fin) begin
            err_q[ch_q]  <= (dec_code == '0) || (dec_code == CODE_MAX);
            pend_q[ch_q] <= 1'b0;
            state_q      <= S_NEXT_CH;
          end else begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign CODE_O[g*CODE_W +: CODE_W] = code_q[g];
    rtermcal_bin2therm #(.CODE_W(CODE_W)) u_b2t (
      .code_i  (code_q[g]),
      .therm_o (THERM_O[g*TW +: TW])
    );
  end

  assign MODE_O = mode_q;
  assign BUSY_O = busy_q;
  assign DONE_O = done_q;
  assign ERR_O  = err_q;

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Scoreboard bench for rtermcal_ctrl: runs are queued with hand-computed results,
// a monitor pops and checks them on every DONE_O pulse.
module tb_rtermcal_ctrl;

  logic        CLK_I = 1'b0;
  logic        RSTN_I = 1'b0;
  logic        START_I = 1'b0;
  logic [1:0]  CH_EN_I = '0;
  logic        ALGO_I = 1'b0;
  logic        CMP_I;
  logic [1:0]  MODE_O;
  logic [7:0]  CODE_O;
  logic [29:0] THERM_O;
  logic        BUSY_O, DONE_O;
  logic [1:0]  ERR_O;

  rtermcal_ctrl #(
    .CODE_W(4), .N_CH(2), .SETTLE_CYC(16), .VOTE_N(3), .RST_CODE(8)
  ) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .START_I(START_I), .CH_EN_I(CH_EN_I),
    .ALGO_I(ALGO_I), .CMP_I(CMP_I), .MODE_O(MODE_O), .CODE_O(CODE_O),
    .THERM_O(THERM_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  int cyc = 0;
  int kstart = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  // Comparator model: 0 = threshold, 1 = stuck high, 2 = stuck low.
  int         cmp_mode = 0;
  logic [3:0] thr0 = 4'd9, thr1 = 4'd11;
  logic       glitch_en = 1'b0;
  logic [3:0] act_code;
  logic       ideal, glitch;

  assign act_code = MODE_O[1] ? CODE_O[7:4] : CODE_O[3:0];
  assign ideal = (cmp_mode == 1) ? 1'b1 :
                 (cmp_mode == 2) ? 1'b0 :
                 (act_code > (MODE_O[1] ? thr1 : thr0));
  assign glitch = glitch_en && ((cyc - kstart) >= 17) && (((cyc - kstart - 17) % 20) == 0);
  assign CMP_I = ideal ^ glitch;

  typedef struct {
    string       name;
    logic [7:0]  codes;
    logic [29:0] therm;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic post_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK_I);
      if (post_chk) begin
        chk("done_one_cycle", 64'(DONE_O), 64'd0);
        chk("busy_after_done", 64'(BUSY_O), 64'd0);
        post_chk = 1'b0;
      end
      if (DONE_O === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done: got DONE_O at cycle %0d expected none", cyc - kstart);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_code"},  64'(CODE_O),  64'(e.codes));
          chk({e.name, "_therm"}, 64'(THERM_O), 64'(e.therm));
          chk({e.name, "_err"},   64'(ERR_O),   64'(e.err));
          chk({e.name, "_lat"},   64'(cyc - kstart), 64'(e.lat));
          chk({e.name, "_mode0"}, 64'(MODE_O),  64'd0);
          chk({e.name, "_busy"},  64'(BUSY_O),  64'd1);
          post_chk = 1'b1;
        end
      end
    end
  end

  task automatic start(input logic [1:0] en, input logic algo, input logic push, input exp_t e);
    @(negedge CLK_I);
    CH_EN_I = en; ALGO_I = algo; START_I = 1'b1;
    if (push) sb.push_back(e);
    @(posedge CLK_I);
    #1;
    kstart = cyc;
    START_I = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - kstart) < n) @(negedge CLK_I);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge CLK_I);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got %0d pending runs expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_mode"},  64'(MODE_O),  64'd0);
    chk({nm, "_busy"},  64'(BUSY_O),  64'd0);
    chk({nm, "_done"},  64'(DONE_O),  64'd0);
    chk({nm, "_err"},   64'(ERR_O),   64'd0);
    chk({nm, "_code"},  64'(CODE_O),  64'h88);
    chk({nm, "_therm"}, 64'(THERM_O), 64'({15'h00FF, 15'h00FF}));
  endtask

  initial begin
    repeat (3) @(negedge CLK_I);
    chk_reset_outputs("reset");
    RSTN_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // Linear on ch1 from 8, threshold 11: trials 8..12, 5 trials.
    thr1 = 4'd11; cmp_mode = 0;
    start(2'b10, 1'b1, 1'b1, '{"lin_ch1", 8'hB8, {15'h07FF, 15'h00FF}, 2'b00, 103});
    wait_done();

    // SAR on ch0, threshold 9: trials 8,12,10,9.
    thr0 = 4'd9;
    start(2'b01, 1'b0, 1'b1, '{"sar_ch0", 8'hB9, {15'h07FF, 15'h01FF}, 2'b00, 83});
    wait_done();

    // Same SAR run with one inverted comparator sample in every vote window.
    glitch_en = 1'b1;
    start(2'b01, 1'b0, 1'b1, '{"sar_vote", 8'hB9, {15'h07FF, 15'h01FF}, 2'b00, 83});
    wait_done();
    glitch_en = 1'b0;

    // Rails: SAR stuck high -> 0, then linear stuck low climbs 0..15 (16 trials).
    cmp_mode = 1;
    start(2'b01, 1'b0, 1'b1, '{"sar_rail0", 8'hB0, {15'h07FF, 15'h0000}, 2'b01, 83});
    wait_done();
    cmp_mode = 2;
    start(2'b01, 1'b1, 1'b1, '{"lin_railmax", 8'hBF, {15'h07FF, 15'h7FFF}, 2'b01, 323});
    wait_done();

    // Both channels SAR, thresholds 5 and 12, with an ignored START mid-run.
    cmp_mode = 0; thr0 = 4'd5; thr1 = 4'd12;
    start(2'b11, 1'b0, 1'b1, '{"sar_both", 8'hC5, {15'h0FFF, 15'h001F}, 2'b00, 165});
    wait_rel(1);
    chk("both_mode_ch0", 64'(MODE_O), 64'b01);
    wait_rel(40);
    chk("both_busy", 64'(BUSY_O), 64'd1);
    CH_EN_I = 2'b01; ALGO_I = 1'b1; START_I = 1'b1;
    @(negedge CLK_I);
    START_I = 1'b0;
    wait_rel(83);
    chk("both_mode_ch1", 64'(MODE_O), 64'b10);
    wait_done();
    repeat (200) @(negedge CLK_I);

    // Reset in the middle of SETTLE aborts straight to reset values.
    thr0 = 4'd9;
    start(2'b01, 1'b0, 1'b0, '{"unused", 8'h00, 30'h0, 2'b00, 0});
    wait_rel(10);
    #2;
    RSTN_I = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge CLK_I);
    RSTN_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    start(2'b01, 1'b0, 1'b1, '{"after_reset", 8'h89, {15'h00FF, 15'h01FF}, 2'b00, 83});
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
